lift_input_conditioner: RTL and testbench
=========================================

# lift_input_conditioner

Front-end stage of the lift controller. Takes the 14 raw, asynchronous field inputs (call buttons, floor/door sensors, limit switches) and synchronizes and debounces them. It presents a clean, glitch-free condition vector x[14:1] to the lift control FSM, plus a change strobe and a glitch-rejection counter for diagnostics. All logic is clocked on the rising edge of clk, so x_out is stable at the falling edge, where the control FSM samples it.

## Interface
- N, 14: number of input channels; bit i-1 carries condition x_i.
- DB_CYCLES, 4: consecutive synchronized samples required to accept a level change; legal range 2..7.
- RST_VAL, 14'b0: reset value of x_out.
- clk  in  1  system clock, rising-edge active.
- rst  in  1  reset; asynchronous, active-high.
- raw_in  in  N  unsynchronized field inputs.
- hold  in  1  when high, x_out is frozen; consumer requests a stable vector.
- x_out  out  N  debounced condition vector to the control FSM.
- x_chg  out  1  one-cycle pulse; at least one x_out bit changed on the previous edge.
- glitch_cnt  out  8  saturating count of cycles in which a pending change was rejected.

## Operation
- Synchronizer: two flops per channel, s1 <= raw_in, s2 <= s1. Only s2 feeds the debouncer.
- Per channel there is a 2-state FSM, STABLE/CHECK, with a 3-bit counter cnt.
  - STABLE, s2 == x_out bit: stay, cnt = 0.
  - STABLE, s2 != x_out bit: go to CHECK, cnt = 1.
  - CHECK, s2 != x_out, cnt < DB_CYCLES-1: cnt + 1.
  - CHECK, s2 != x_out, cnt == DB_CYCLES-1, hold = 0: toggle the x_out bit, go to STABLE, cnt = 0.
  - CHECK, s2 != x_out, cnt == DB_CYCLES-1, hold = 1: stay in CHECK, cnt held. Commit on the first edge with hold = 0 if s2 still differs.
  - CHECK, s2 == x_out: rejected glitch. Go to STABLE, cnt = 0, and flag reject.
- glitch_cnt increments by exactly 1 on any edge where one or more channels flag reject, regardless of how many. It saturates at 255 and never wraps.
- x_chg is registered. It is 1 for the cycle after any commit edge, else 0. Simultaneous commits on several channels produce a single pulse.
- hold has no effect on the synchronizer, cnt progress below DB_CYCLES-1, or glitch rejection.
- While x_out is frozen, x_chg stays 0.

## Timing
- Reset (async assert, synchronous to clk on release):
  - s1 = s2 = RST_VAL.
  - x_out = RST_VAL.
  - All channels STABLE with cnt = 0.
  - x_chg = 0, glitch_cnt = 0.
- Latency, for a raw change captured into s1 at edge E0:
  - s2 updates at E1.
  - CHECK is entered at E2.
  - x_out commits at E(DB_CYCLES+1); with the default, E5.
  - x_chg is high from E(DB_CYCLES+2) until the next edge.
- Acceptance requires DB_CYCLES consecutive differing s2 samples. A pulse shorter than DB_CYCLES cycles at s2 never reaches x_out.
- Reset mid-CHECK discards the pending change. x_out returns to RST_VAL immediately, with no x_chg pulse.
- A channel that commits and whose s2 reverts on the very next edge starts a new STABLE-to-CHECK sequence. The minimum spacing between x_out toggles is DB_CYCLES+1 edges.

## Test plan
- Reset: assert rst with raw_in = 14'h3FFF mid-cycle. Required:
  - x_out = 0, x_chg = 0 and glitch_cnt = 0 immediately, with no clock.
  - After release, x_out = 14'h3FFF at the 5th rising edge after the first capture edge.
- Clean edge: raw_in[0] goes 0->1 and is held. Required:
  - x_out[0] rises exactly at E5 (DB_CYCLES = 4).
  - x_chg is high for the one cycle following E5.
  - glitch_cnt stays 0.
- Glitch: raw_in[3] high for 2 cycles, then low. Required:
  - x_out[3] stays 0.
  - glitch_cnt = 1.
  - x_chg never asserts.
- Multi-channel glitch: raw_in[1] and raw_in[7] both pulse for 3 cycles in the same cycles. Required: glitch_cnt increments by exactly 1 and x_out is unchanged.
- Hold: raw_in[5] rises, hold = 1 from E3 to E8. Required:
  - x_out[5] stays 0 through E8 and commits at the first edge with hold = 0.
  - Exactly one x_chg pulse follows.
- Saturation and reset mid-CHECK:
  - Apply 300 rejected glitches. Required: glitch_cnt = 255.
  - Then start a change on raw_in[2] and assert rst at E3. Required: x_out = 0, glitch_cnt = 0, no commit afterwards.

Source files
------------

// File: rtl/lift_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : lift_input_conditioner
// Description : Front-end conditioning of the lift controller's raw field
//               inputs. Every channel passes through a two-flop synchronizer
//               and a per-channel STABLE/CHECK debouncer. A level change is
//               accepted only after DB_CYCLES consecutive differing samples,
//               and it can be held back while the consumer asserts hold.
//               The block also reports a change strobe and keeps a saturating
//               count of rejected glitches.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous, active-high reset
//               raw_in     - N unsynchronized field inputs
//               hold       - freeze x_out (commits wait while high)
//               x_out      - debounced condition vector
//               x_chg      - one-cycle pulse, x_out changed on previous edge
//               glitch_cnt - saturating count of cycles with a rejection
// Revision    : 1.0 - initial release
// ============================================================================
module lift_input_conditioner #(
    parameter int           N         = 14,
    parameter int           DB_CYCLES = 4,
    parameter logic [N-1:0] RST_VAL   = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] raw_in,
    input  logic         hold,
    output logic [N-1:0] x_out,
    output logic         x_chg,
    output logic [7:0]   glitch_cnt
);

    // Last count value before a change is accepted.
    localparam logic [2:0] c_cnt_max = 3'(DB_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } chan_state_t;

    // Synchronizer
    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;

    // Debouncer state per channel
    chan_state_t  state_q [N];
    chan_state_t  state_d [N];
    logic [2:0]   cnt_q   [N];
    logic [2:0]   cnt_d   [N];
    logic [N-1:0] x_q, x_d;

    // Per-channel events on the current edge
    logic [N-1:0] w_commit;
    logic [N-1:0] w_reject;
    logic [N-1:0] w_diff;

    // Diagnostics
    logic         commit_any_q, commit_any_d;
    logic         x_chg_q, x_chg_d;
    logic [7:0]   glitch_q, glitch_d;

    assign w_diff = sync2_q ^ x_q;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        x_d      = x_q;
        w_commit = '0;
        w_reject = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (w_diff[i]) begin
                        state_d[i] = ST_CHECK;
                        cnt_d[i]   = 3'd1;
                    end else begin
                        cnt_d[i]   = 3'd0;
                    end
                end
                ST_CHECK: begin
                    if (!w_diff[i]) begin
                        // Input reverted before acceptance: drop it.
                        state_d[i]  = ST_STABLE;
                        cnt_d[i]    = 3'd0;
                        w_reject[i] = 1'b1;
                    end else if (cnt_q[i] < c_cnt_max) begin
                        cnt_d[i] = cnt_q[i] + 3'd1;
                    end else if (!hold) begin
                        x_d[i]      = ~x_q[i];
                        state_d[i]  = ST_STABLE;
                        cnt_d[i]    = 3'd0;
                        w_commit[i] = 1'b1;
                    end
                    // else: fully qualified but frozen by hold; wait here.
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = 3'd0;
                end
            endcase
        end

        // The commit edge updates x_out; the strobe follows one edge later,
        // so it flags a change that happened on the previous edge.
        commit_any_d = |w_commit;
        x_chg_d      = commit_any_q;

        // One step per edge no matter how many channels reject together.
        glitch_d = glitch_q;
        if ((|w_reject) && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= RST_VAL;
            sync2_q      <= RST_VAL;
            x_q          <= RST_VAL;
            commit_any_q <= 1'b0;
            x_chg_q      <= 1'b0;
            glitch_q     <= 8'd0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= 3'd0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            x_q          <= x_d;
            commit_any_q <= commit_any_d;
            x_chg_q      <= x_chg_d;
            glitch_q     <= glitch_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign x_out      = x_q;
    assign x_chg      = x_chg_q;
    assign glitch_cnt = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_lift_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_input_conditioner
// Description : Self-checking bench for lift_input_conditioner. Table-driven
//               per-edge vectors for the clean edge and glitch cases, plus
//               hand-written sequences for reset, multi-channel glitch, hold,
//               saturation and reset during CHECK.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lift_input_conditioner;

    logic        clk;
    logic        rst;
    logic [13:0] raw_in;
    logic        hold;
    logic [13:0] x_out;
    logic        x_chg;
    logic [7:0]  glitch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    lift_input_conditioner #(
        .N         (14),
        .DB_CYCLES (4),
        .RST_VAL   (14'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .hold       (hold),
        .x_out      (x_out),
        .x_chg      (x_chg),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] raw;
        logic        hold;
        logic [13:0] exp_x;
        logic        exp_chg;
        logic [7:0]  exp_g;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One rising edge, then sample just after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;

        rst    = 1'b0;
        raw_in = 14'h0;
        hold   = 1'b0;

        // ---------------- reset ----------------
        #12;
        raw_in = 14'h3FFF;
        rst    = 1'b1;
        #1;
        chk("rst_x_async", 32'(x_out), 32'h0);
        chk("rst_chg_async", 32'(x_chg), 32'h0);
        chk("rst_g_async", 32'(glitch_cnt), 32'h0);
        tick;
        rst = 1'b0;
        // Next edge is E0 (first capture).
        for (int e = 0; e <= 5; e++) begin
            tick;
            if (e == 4) chk("rst_rel_x_E4", 32'(x_out), 32'h0);
            if (e == 5) chk("rst_rel_x_E5", 32'(x_out), 32'h3FFF);
        end
        tick;
        chk("rst_rel_chg_E6", 32'(x_chg), 32'h1);
        tick;
        chk("rst_rel_chg_E7", 32'(x_chg), 32'h0);

        // Back to an all-zero start.
        rst    = 1'b1;
        raw_in = 14'h0;
        tick;
        rst = 1'b0;
        tick; tick; tick;
        chk("rst2_x", 32'(x_out), 32'h0);

        // ---------------- table: clean edge then glitch ----------------
        // Clean 0->1 on bit 0, rows are E0..E7.
        for (int e = 0; e <= 7; e++)
            vecs.push_back('{14'h0001, 1'b0, (e >= 5) ? 14'h0001 : 14'h0000,
                             (e == 6) ? 1'b1 : 1'b0, 8'd0});
        // Bit 3 high for two edges: rejected at E4.
        for (int e = 0; e <= 6; e++)
            vecs.push_back('{(e < 2) ? 14'h0009 : 14'h0001, 1'b0, 14'h0001, 1'b0,
                             (e >= 4) ? 8'd1 : 8'd0});

        foreach (vecs[i]) begin
            raw_in = vecs[i].raw;
            hold   = vecs[i].hold;
            tick;
            chk($sformatf("vec%0d_x", i), 32'(x_out), 32'(vecs[i].exp_x));
            chk($sformatf("vec%0d_chg", i), 32'(x_chg), 32'(vecs[i].exp_chg));
            chk($sformatf("vec%0d_g", i), 32'(glitch_cnt), 32'(vecs[i].exp_g));
        end

        // ---------------- multi-channel glitch ----------------
        seen = 0;
        for (int e = 0; e <= 9; e++) begin
            raw_in = (e < 3) ? 14'h0083 : 14'h0001;
            tick;
            if (x_chg) seen++;
            if (e == 4) chk("multi_g_E4", 32'(glitch_cnt), 32'd1);
            if (e == 5) chk("multi_g_E5", 32'(glitch_cnt), 32'd2);
        end
        chk("multi_x", 32'(x_out), 32'h0001);
        chk("multi_g_end", 32'(glitch_cnt), 32'd2);
        chk("multi_no_chg", 32'(seen), 32'd0);

        // ---------------- hold ----------------
        seen = 0;
        for (int e = 0; e <= 12; e++) begin
            raw_in = 14'h0021;
            hold   = (e >= 3 && e <= 8);
            tick;
            if (x_chg) seen++;
            if (e >= 4 && e <= 8) chk($sformatf("hold_x_E%0d", e), 32'(x_out), 32'h0001);
            if (e == 9)  chk("hold_commit_E9", 32'(x_out), 32'h0021);
            if (e == 9)  chk("hold_chg_E9", 32'(x_chg), 32'h0);
            if (e == 10) chk("hold_chg_E10", 32'(x_chg), 32'h1);
            if (e == 11) chk("hold_chg_E11", 32'(x_chg), 32'h0);
        end
        hold = 1'b0;
        chk("hold_one_pulse", 32'(seen), 32'd1);
        chk("hold_g", 32'(glitch_cnt), 32'd2);

        // ---------------- saturation ----------------
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            raw_in = 14'h0031;
            tick;
            if (x_chg) seen++;
            raw_in = 14'h0021;
            for (int j = 0; j < 3; j++) begin
                tick;
                if (x_chg) seen++;
            end
            if (k == 9) chk("sat_g_10", 32'(glitch_cnt), 32'd12);
        end
        tick; tick; tick; tick;
        chk("sat_g_255", 32'(glitch_cnt), 32'd255);
        chk("sat_x", 32'(x_out), 32'h0021);
        chk("sat_no_chg", 32'(seen), 32'd0);

        // ---------------- reset mid-CHECK ----------------
        raw_in = 14'h0025;
        tick; tick; tick;           // E0, E1, E2 (CHECK entered)
        chk("midchk_x_pre", 32'(x_out), 32'h0021);
        #2;
        rst    = 1'b1;
        raw_in = 14'h0000;
        #1;
        chk("midchk_rst_x", 32'(x_out), 32'h0);
        chk("midchk_rst_g", 32'(glitch_cnt), 32'h0);
        chk("midchk_rst_chg", 32'(x_chg), 32'h0);
        tick; tick;
        rst = 1'b0;
        seen = 0;
        for (int e = 0; e < 10; e++) begin
            tick;
            if (x_chg || (x_out != 14'h0)) seen++;
        end
        chk("midchk_no_commit", 32'(seen), 32'd0);
        chk("midchk_g_after", 32'(glitch_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
